// File: rtl/line_fifo_reader.sv
// Line-buffer window reader: each pass streams KERNEL_ROWS lines, then retires STRIDE lines.
// Define LINE_FIFO_READER_OVERRUN_CHECK_EN to flag writes into a full buffer on o_overrun.

module line_fifo_reader #(
  parameter int unsigned DATA_WIDTH     = 144,
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned WORDS_PER_LINE = 57,
  parameter int unsigned NUM_LINES      = 15,
  parameter int unsigned KERNEL_ROWS    = 11,
  parameter int unsigned STRIDE         = 4,
  parameter int unsigned RD_LATENCY     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [7:0]            i_out_rows,
  input  logic                  i_line_written,
  input  logic                  i_mlp_ready,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [3:0]            o_row_idx,
  output logic                  o_last_word,
  output logic                  o_last_row,
  output logic                  o_space_avail,
  output logic                  o_image_done,
  output logic                  o_overrun
);

  localparam int unsigned DEPTH   = WORDS_PER_LINE * NUM_LINES;
  localparam int unsigned ADVANCE = (STRIDE * WORDS_PER_LINE) % DEPTH;
  localparam int unsigned AW1     = ADDR_WIDTH + 1;
  localparam int unsigned WCW     = $clog2(WORDS_PER_LINE);
  localparam int unsigned LAW     = $clog2(NUM_LINES + 1);

  typedef enum logic [2:0] {IDLE, WAIT, READ, RETIRE, DONE} state_t;

  state_t                state, state_next;
  logic [LAW-1:0]        lines_avail, lines_next;
  logic [ADDR_WIDTH-1:0] base_addr, rd_addr, addr_next, base_next;
  logic [AW1-1:0]        addr_sum, base_sum;
  logic [WCW-1:0]        word_cnt;
  logic [3:0]            row_cnt;
  logic [7:0]            pass_cnt, out_rows;
  logic                  rd_en, image_done, space_avail;
  logic                  last_word_c, last_row_c, retire_c, accept_c;

  logic                  pipe_valid [RD_LATENCY];
  logic [3:0]            pipe_row   [RD_LATENCY];
  logic                  pipe_lw    [RD_LATENCY];
  logic                  pipe_lr    [RD_LATENCY];

  assign last_word_c = (word_cnt == WCW'(WORDS_PER_LINE - 1));
  assign last_row_c  = (row_cnt == 4'(KERNEL_ROWS - 1));
  assign retire_c    = (state == RETIRE);
  assign accept_c    = i_line_written && (lines_avail < LAW'(NUM_LINES));

  // Modulo-DEPTH address steps by compare-and-subtract
  always_comb begin
    addr_sum  = {1'b0, rd_addr} + AW1'(1);
    base_sum  = {1'b0, base_addr} + AW1'(ADVANCE);
    addr_next = (addr_sum >= AW1'(DEPTH)) ? ADDR_WIDTH'(addr_sum - AW1'(DEPTH))
                                          : ADDR_WIDTH'(addr_sum);
    base_next = (base_sum >= AW1'(DEPTH)) ? ADDR_WIDTH'(base_sum - AW1'(DEPTH))
                                          : ADDR_WIDTH'(base_sum);
  end

  // Occupancy: saturating write count, minus STRIDE on retire
  always_comb begin
    lines_next = lines_avail;
    if (accept_c) lines_next = lines_next + LAW'(1);
    if (retire_c) lines_next = lines_next - LAW'(STRIDE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   state_next = IDLE;
      WAIT: begin
        if (out_rows == 8'd0)
          state_next = DONE;
        else if ((lines_avail >= LAW'(KERNEL_ROWS)) && i_mlp_ready)
          state_next = READ;
      end
      READ:   if (last_word_c && last_row_c) state_next = RETIRE;
      RETIRE: state_next = (({1'b0, pass_cnt} + 9'd1) == {1'b0, out_rows}) ? DONE : WAIT;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (i_start) state_next = WAIT;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      lines_avail <= '0;
      base_addr   <= '0;
      rd_addr     <= '0;
      word_cnt    <= '0;
      row_cnt     <= '0;
      pass_cnt    <= '0;
      out_rows    <= '0;
      rd_en       <= 1'b0;
      image_done  <= 1'b0;
      space_avail <= 1'b1;
    end else if (i_start) begin
      lines_avail <= '0;
      base_addr   <= '0;
      rd_addr     <= '0;
      word_cnt    <= '0;
      row_cnt     <= '0;
      pass_cnt    <= '0;
      out_rows    <= i_out_rows;
      rd_en       <= 1'b0;
      image_done  <= 1'b0;
      space_avail <= 1'b1;
    end else begin
      lines_avail <= lines_next;
      space_avail <= (lines_next < LAW'(NUM_LINES));
      rd_en       <= (state_next == READ);
      image_done  <= (state_next == DONE);
      if (state == WAIT && state_next == READ) begin
        rd_addr  <= base_addr;
        word_cnt <= '0;
        row_cnt  <= '0;
      end else if (state == READ) begin
        rd_addr <= addr_next;
        if (last_word_c) begin
          word_cnt <= '0;
          row_cnt  <= row_cnt + 4'd1;
        end else begin
          word_cnt <= word_cnt + WCW'(1);
        end
      end
      if (retire_c) begin
        base_addr <= base_next;
        pass_cnt  <= pass_cnt + 8'd1;
      end
    end
  end

  // Sideband shift pipeline matching the buffer read latency; i_start flushes it
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_start) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_row[i]   <= '0;
        pipe_lw[i]    <= 1'b0;
        pipe_lr[i]    <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= rd_en;
      pipe_row[0]   <= rd_en ? row_cnt : 4'd0;
      pipe_lw[0]    <= rd_en && last_word_c;
      pipe_lr[0]    <= rd_en && last_row_c;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_row[i]   <= pipe_row[i-1];
        pipe_lw[i]    <= pipe_lw[i-1];
        pipe_lr[i]    <= pipe_lr[i-1];
      end
    end
  end

`ifdef LINE_FIFO_READER_OVERRUN_CHECK_EN
  logic overrun;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_start)
      overrun <= 1'b0;
    else if (i_line_written && (lines_avail == LAW'(NUM_LINES)))
      overrun <= 1'b1;
  end

  assign o_overrun = overrun;
`else
  assign o_overrun = 1'b0;
`endif

  assign o_rd_en       = rd_en;
  assign o_rd_addr     = rd_addr;
  assign o_data        = i_rd_data;
  assign o_valid       = pipe_valid[RD_LATENCY-1];
  assign o_row_idx     = pipe_row[RD_LATENCY-1];
  assign o_last_word   = pipe_lw[RD_LATENCY-1];
  assign o_last_row    = pipe_lr[RD_LATENCY-1];
  assign o_space_avail = space_avail;
  assign o_image_done  = image_done;

endmodule

// File: tb/tb_line_fifo_reader.sv
// Self-checking bench for line_fifo_reader: randomized writes/ready against a pass-level model.
// Honors LINE_FIFO_READER_OVERRUN_CHECK_EN for the expected o_overrun value.

module tb_line_fifo_reader;

  localparam int DW     = 144;
  localparam int AW     = 11;
  localparam int WPL    = 57;
  localparam int NL     = 15;
  localparam int KR     = 11;
  localparam int STRIDE = 4;
  localparam int RL     = 2;
  localparam int DEPTH  = WPL * NL;
  localparam int NBEAT  = WPL * KR;
  localparam int PASS_CYCLES = NBEAT + RL;
`ifdef LINE_FIFO_READER_OVERRUN_CHECK_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, start, line_written, mlp_ready;
  logic [7:0]    out_rows;
  logic          rd_en, valid, last_word, last_row, space_avail, image_done, overrun;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, data;
  logic [3:0]    row_idx;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_q;

  int n_cmp = 0;
  int n_fail = 0;
  int la = 0;
  int pass_idx = 0;

  line_fifo_reader dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_out_rows(out_rows),
    .i_line_written(line_written), .i_mlp_ready(mlp_ready),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_data(data),
    .o_valid(valid), .o_row_idx(row_idx), .o_last_word(last_word), .o_last_row(last_row),
    .o_space_avail(space_avail), .o_image_done(image_done), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  // Line buffer RAM with two-cycle read latency
  always @(posedge clk) begin
    ra_q    <= rd_addr;
    rd_data <= (int'(ra_q) < DEPTH) ? mem[ra_q] : '0;
  end

  task automatic do_start(input int rows);
    out_rows = 8'(rows);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    la = 0;
    pass_idx = 0;
  endtask

  task automatic write_lines(input int n);
    for (int i = 0; i < n; i++) begin
      line_written = 1'b1;
      @(negedge clk);
      if (la < NL) la++;
    end
    line_written = 1'b0;
  endtask

  // One full pass: base from pass index, every cycle checked against the model.
  // wr_mode: 0 no writes, 1 random writes, 2 single write in the retire cycle.
  task automatic run_pass(input int wr_mode, input bit final_pass);
    int base, n, k;
    logic [164:0] exp_v, obs_v;
    logic         e_rd, e_val, e_lw, e_lr, e_done;
    logic [AW-1:0] e_addr, o_addr;
    logic [3:0]    e_row, o_row;
    logic [DW-1:0] e_data, o_dat;
    logic          o_lw, o_lr;
    base = (pass_idx * STRIDE * WPL) % DEPTH;
    n = 0;
    while (!rd_en && n < 300) begin
      n_cmp++;
      if (space_avail !== (la < NL)) begin
        n_fail++;
        $display("FAIL space_wait pass=%0d got %b want %b", pass_idx, space_avail, la < NL);
      end
      line_written = (wr_mode == 1 && la < NL) ? 1'($urandom % 2) : 1'b0;
      la += int'(line_written);
      mlp_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    line_written = 1'b0;
    n_cmp++;
    if (rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_start pass=%0d got rd_en=%b want 1 within 300 cycles", pass_idx, rd_en);
      return;
    end
    for (int c = 0; c < PASS_CYCLES; c++) begin
      e_rd   = (c < NBEAT);
      e_addr = e_rd ? AW'((base + c) % DEPTH) : '0;
      o_addr = e_rd ? rd_addr : '0;
      e_val  = (c >= RL) && (c < NBEAT + RL);
      e_row = '0; e_lw = 1'b0; e_lr = 1'b0; e_data = '0;
      o_row = '0; o_lw = 1'b0; o_lr = 1'b0; o_dat = '0;
      if (e_val) begin
        k      = c - RL;
        e_row  = 4'(k / WPL);
        e_lw   = ((k % WPL) == WPL - 1);
        e_lr   = ((k / WPL) == KR - 1);
        e_data = mem[(base + k) % DEPTH];
        o_row = row_idx; o_lw = last_word; o_lr = last_row; o_dat = data;
      end
      e_done = final_pass && (c == NBEAT + 1);
      exp_v = {e_rd, e_addr, e_val, e_row, e_lw, e_lr, e_done, 1'(la < NL), e_data};
      obs_v = {rd_en, o_addr, valid, o_row, o_lw, o_lr, image_done, space_avail, o_dat};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL beat pass=%0d c=%0d got %h want %h", pass_idx, c, obs_v, exp_v);
      end
      if (wr_mode == 1) line_written = (la < NL) ? 1'($urandom % 2) : 1'b0;
      else if (wr_mode == 2) line_written = (c == NBEAT && la < NL);
      else line_written = 1'b0;
      mlp_ready = (c < NBEAT - 1) ? 1'($urandom % 2) : 1'b1;
      la += int'(line_written);
      if (c == NBEAT) la -= STRIDE;
      @(negedge clk);
    end
    line_written = 1'b0;
    mlp_ready = 1'b1;
    pass_idx++;
  endtask

  task automatic test_reset;
    logic [22:0] obs;
    reset_n = 1'b0; start = 1'b0; out_rows = '0; line_written = 1'b0; mlp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      line_written = 1'($urandom % 2);
      mlp_ready = 1'($urandom % 2);
      @(negedge clk);
      obs = {rd_en, valid, last_word, last_row, image_done, overrun, rd_addr, row_idx, space_avail};
      n_cmp++;
      if (obs !== {6'b0, 11'd0, 4'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_during i=%0d got %h want %h", i, obs, {6'b0, 11'd0, 4'd0, 1'b1});
      end
    end
    line_written = 1'b0; mlp_ready = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {rd_en, valid, last_word, last_row, image_done, overrun, rd_addr, row_idx, space_avail};
      n_cmp++;
      if (obs !== {6'b0, 11'd0, 4'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_after i=%0d got %h want %h", i, obs, {6'b0, 11'd0, 4'd0, 1'b1});
      end
    end
    la = 0;
  endtask

  task automatic test_single_pass;
    do_start(1);
    mlp_ready = 1'b1;
    write_lines(KR);
    run_pass(1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({image_done, rd_en} !== 2'b00) begin
        n_fail++;
        $display("FAIL single_idle i=%0d got done,rd_en=%b%b want 00", i, image_done, rd_en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_two_pass;
    do_start(2);
    mlp_ready = 1'b0;
    write_lines(NL);
    run_pass(0, 1'b0);
    run_pass(0, 1'b1);
    write_lines(7);
    n_cmp++;
    if (space_avail !== (la < NL)) begin
      n_fail++;
      $display("FAIL two_pass_space7 got %b want %b (lines=%0d)", space_avail, la < NL, la);
    end
    write_lines(1);
    n_cmp++;
    if (space_avail !== (la < NL)) begin
      n_fail++;
      $display("FAIL two_pass_space8 got %b want %b (lines=%0d)", space_avail, la < NL, la);
    end
  endtask

  task automatic test_wrap;
    do_start(4);
    mlp_ready = 1'b1;
    write_lines(KR);
    for (int p = 0; p < 4; p++) run_pass(1, p == 3);
  endtask

  task automatic test_retire_write;
    do_start(1);
    mlp_ready = 1'b0;
    write_lines(KR);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_wait i=%0d got rd_en=%b want 0", i, rd_en);
      end
      @(negedge clk);
    end
    mlp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_release got rd_en=%b want 1", rd_en);
    end
    run_pass(2, 1'b1);
    write_lines(6);
    n_cmp++;
    if (space_avail !== (la < NL)) begin
      n_fail++;
      $display("FAIL retire_write_space6 got %b want %b (lines=%0d)", space_avail, la < NL, la);
    end
    write_lines(1);
    n_cmp++;
    if (space_avail !== (la < NL)) begin
      n_fail++;
      $display("FAIL retire_write_space7 got %b want %b (lines=%0d)", space_avail, la < NL, la);
    end
  endtask

  task automatic test_zero_rows;
    int pulses, rd_seen;
    do_start(0);
    mlp_ready = 1'b1;
    pulses = 0; rd_seen = 0;
    for (int i = 0; i < 14; i++) begin
      pulses += int'(image_done);
      rd_seen += int'(rd_en);
      line_written = 1'b1;
      @(negedge clk);
    end
    line_written = 1'b0;
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL zero_rows_done got %0d pulses want 1", pulses);
    end
    n_cmp++;
    if (rd_seen != 0) begin
      n_fail++;
      $display("FAIL zero_rows_rd got %0d rd_en cycles want 0", rd_seen);
    end
  endtask

  task automatic test_overrun_abort;
    do_start(1);
    mlp_ready = 1'b0;
    write_lines(NL);
    n_cmp++;
    if ({space_avail, overrun} !== {1'(la < NL), 1'b0}) begin
      n_fail++;
      $display("FAIL full_15 got space,ovr=%b%b want %b0", space_avail, overrun, la < NL);
    end
    write_lines(1);
    n_cmp++;
    if ({space_avail, overrun} !== {1'(la < NL), OVR_EN}) begin
      n_fail++;
      $display("FAIL overrun_16 got space,ovr=%b%b want %b%b", space_avail, overrun, la < NL, OVR_EN);
    end
    mlp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_read_start got rd_en=%b want 1", rd_en);
    end
    repeat ($urandom_range(20, 300)) @(negedge clk);
    n_cmp++;
    if ({rd_en, valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_read got rd_en,valid=%b%b want 11", rd_en, valid);
    end
    do_start(1);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({rd_en, valid, overrun} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_flush i=%0d got rd_en,valid,ovr=%b%b%b want 000", i, rd_en, valid, overrun);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [159:0] t;
    for (int i = 0; i < DEPTH; i++) begin
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      mem[i] = t[DW-1:0];
    end
    test_reset();
    test_single_pass();
    test_two_pass();
    test_wrap();
    test_retire_write();
    test_zero_rows();
    test_overrun_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
